spi_transmitter: RTL and testbench

SPI_TRANSMITTER -- requirements
Module: spi_transmitter

---
 rtl/spi_pkg.sv | 19 +
 rtl/spi_clk_div.sv | 38 +++
 rtl/spi_transmitter.sv | 139 +++++++++++++
 tb/tb_spi_transmitter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI transmitter slice.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        HOLD
    } spi_state_e;

    // Serial clock levels packed as {SCK_HP, SCK_LP, SCK_HN, SCK_LN}
    localparam logic [3:0] SCK_IDLE   = 4'b1010;
    localparam logic [3:0] SCK_FIRST  = 4'b0011;
    localparam logic [3:0] SCK_SECOND = 4'b1100;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator: pulses once every P_CLK_DIV cycles while enabled.
module spi_clk_div
    import spi_pkg::*;
#(
    parameter int unsigned P_CLK_DIV = 1
) (
    input  logic clk_100,
    input  logic a_rst,
    input  logic s_rst,
    input  logic en_i,
    output logic tick_o
);

    localparam int unsigned CW = cnt_width(P_CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(P_CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Counter is held at zero while disabled so the first half starts aligned to acceptance
    always_comb begin
        cnt_d  = cnt_q;
        tick_o = 1'b0;
        if (!en_i || s_rst) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            tick_o = 1'b1;
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_100 or posedge a_rst) begin
        if (a_rst) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/spi_transmitter.sv
// SPI master transmitter: MSB-first shift with four SCK flavours, all outputs registered.
module spi_transmitter
    import spi_pkg::*;
#(
    parameter int unsigned P_DATA_WIDTH = 8,
    parameter int unsigned P_CLK_DIV    = 1,
    parameter logic        P_CS_POLAR   = 1'b0
) (
    input  logic                    clk_100,
    input  logic                    a_rst,
    input  logic                    s_rst,
    input  logic                    valid,
    input  logic [P_DATA_WIDTH-1:0] data,
    output logic                    ready,
    output logic                    MOSI,
    output logic                    CS,
    output logic                    SCK_HP,
    output logic                    SCK_LP,
    output logic                    SCK_HN,
    output logic                    SCK_LN
);

    localparam int unsigned BW = cnt_width(P_DATA_WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(P_DATA_WIDTH - 1);

    spi_state_e              state_q, state_d;
    logic                    half_q, half_d;
    logic [BW-1:0]           bit_q, bit_d;
    logic [P_DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                    ready_q, ready_d;
    logic                    cs_q, cs_d;
    logic                    mosi_q, mosi_d;
    logic [3:0]              sck_q, sck_d;
    logic                    tick;

    spi_clk_div #(
        .P_CLK_DIV(P_CLK_DIV)
    ) u_clk_div (
        .clk_100 (clk_100),
        .a_rst   (a_rst),
        .s_rst   (s_rst),
        .en_i    (state_q != IDLE),
        .tick_o  (tick)
    );

    always_comb begin
        state_d = state_q;
        half_d  = half_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        ready_d = ready_q;
        cs_d    = cs_q;
        mosi_d  = mosi_q;
        sck_d   = sck_q;

        case (state_q)
            IDLE: begin
                if (valid) begin
                    state_d = SHIFT;
                    shreg_d = data;
                    bit_d   = '0;
                    half_d  = 1'b0;
                    ready_d = 1'b0;
                    cs_d    = P_CS_POLAR;
                    mosi_d  = data[P_DATA_WIDTH-1];
                    sck_d   = SCK_FIRST;
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (!half_q) begin
                        half_d = 1'b1;
                        sck_d  = SCK_SECOND;
                    end else if (bit_q == LAST_BIT) begin
                        state_d = HOLD;
                        sck_d   = SCK_IDLE;
                        mosi_d  = 1'b0;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        half_d  = 1'b0;
                        shreg_d = shreg_q << 1;
                        mosi_d  = shreg_d[P_DATA_WIDTH-1];
                        sck_d   = SCK_FIRST;
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                    cs_d    = ~P_CS_POLAR;
                end
            end
            default: state_d = IDLE;
        endcase

        if (s_rst) begin
            state_d = IDLE;
            half_d  = 1'b0;
            bit_d   = '0;
            shreg_d = '0;
            ready_d = 1'b1;
            cs_d    = ~P_CS_POLAR;
            mosi_d  = 1'b0;
            sck_d   = SCK_IDLE;
        end
    end

    always_ff @(posedge clk_100 or posedge a_rst) begin
        if (a_rst) begin
            state_q <= IDLE;
            half_q  <= 1'b0;
            bit_q   <= '0;
            shreg_q <= '0;
            ready_q <= 1'b1;
            cs_q    <= ~P_CS_POLAR;
            mosi_q  <= 1'b0;
            sck_q   <= SCK_IDLE;
        end else begin
            state_q <= state_d;
            half_q  <= half_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            ready_q <= ready_d;
            cs_q    <= cs_d;
            mosi_q  <= mosi_d;
            sck_q   <= sck_d;
        end
    end

    assign ready  = ready_q;
    assign CS     = cs_q;
    assign MOSI   = mosi_q;
    assign SCK_HP = sck_q[3];
    assign SCK_LP = sck_q[2];
    assign SCK_HN = sck_q[1];
    assign SCK_LN = sck_q[0];

endmodule

// File: tb/tb_spi_transmitter.sv
// Bench for spi_transmitter: default instance plus a divided, active-high-CS instance against a timeline model.
module tb_spi_transmitter;

    logic       clk_100 = 1'b0;
    logic       a_rst   = 1'b0;
    logic       s_rst   = 1'b0;
    logic       valid0  = 1'b0;
    logic       valid1  = 1'b0;
    logic [7:0] data0   = '0;
    logic [7:0] data1   = '0;

    logic r0, cs0, mosi0, hp0, lp0, hn0, ln0;
    logic r1, cs1, mosi1, hp1, lp1, hn1, ln1;

    int n_total = 0;
    int n_pass  = 0;
    bit chk_en  = 1'b0;

    // Output vectors ordered {ready, CS, MOSI, HP, LP, HN, LN}
    localparam logic [6:0] IDLE0 = 7'b1101010;
    localparam logic [6:0] IDLE1 = 7'b1001010;

    always #5 clk_100 = ~clk_100;

    spi_transmitter dut0 (
        .clk_100(clk_100), .a_rst(a_rst), .s_rst(s_rst), .valid(valid0), .data(data0),
        .ready(r0), .MOSI(mosi0), .CS(cs0),
        .SCK_HP(hp0), .SCK_LP(lp0), .SCK_HN(hn0), .SCK_LN(ln0)
    );

    spi_transmitter #(
        .P_DATA_WIDTH(8),
        .P_CLK_DIV(3),
        .P_CS_POLAR(1'b1)
    ) dut1 (
        .clk_100(clk_100), .a_rst(a_rst), .s_rst(s_rst), .valid(valid1), .data(data1),
        .ready(r1), .MOSI(mosi1), .CS(cs1),
        .SCK_HP(hp1), .SCK_LP(lp1), .SCK_HN(hn1), .SCK_LN(ln1)
    );

    wire [6:0] out0 = {r0, cs0, mosi0, hp0, lp0, hn0, ln0};
    wire [6:0] out1 = {r1, cs1, mosi1, hp1, lp1, hn1, ln1};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        else n_pass++;
    endtask

    // Expected outputs k cycles after acceptance of word w
    function automatic logic [6:0] model_out(input bit busy, input int k, input logic [7:0] w,
                                             input int d, input bit pol);
        int bidx;
        bit second;
        if (!busy) return {1'b1, ~pol, 1'b0, 4'b1010};
        bidx   = k / (2 * d);
        second = ((k / d) % 2) == 1;
        if (bidx < 8) return {1'b0, pol, w[7 - bidx], second ? 4'b1100 : 4'b0011};
        return {1'b0, pol, 1'b0, 4'b1010};
    endfunction

    bit busy0 = 1'b0, busy1 = 1'b0;
    int k0 = 0, k1 = 0;
    logic [7:0] w0 = '0, w1 = '0;

    always @(posedge clk_100 or posedge a_rst) begin
        if (a_rst || s_rst) busy0 <= 1'b0;
        else if (!busy0) begin
            if (valid0) begin busy0 <= 1'b1; k0 <= 0; w0 <= data0; end
        end else if (k0 == 17 * 1 - 1) busy0 <= 1'b0;
        else k0 <= k0 + 1;
    end

    always @(posedge clk_100 or posedge a_rst) begin
        if (a_rst || s_rst) busy1 <= 1'b0;
        else if (!busy1) begin
            if (valid1) begin busy1 <= 1'b1; k1 <= 0; w1 <= data1; end
        end else if (k1 == 17 * 3 - 1) busy1 <= 1'b0;
        else k1 <= k1 + 1;
    end

    always @(negedge clk_100) begin
        if (chk_en) begin
            check("cyc_dut0", out0, model_out(busy0, k0, w0, 1, 1'b0));
            check("cyc_dut1", out1, model_out(busy1, k1, w1, 3, 1'b1));
        end
    end

    task automatic step();
        @(posedge clk_100);
        #2;
    endtask

    initial begin
        int cs0_low, cs1_high, lp0_rise, hn1_fall;
        logic prev_lp0, prev_hn1;
        logic [15:0] mos0;
        logic [7:0]  mos1;
        bit found;

        #1 a_rst = 1'b1;
        #20 a_rst = 1'b0;
        s_rst = 1'b1;
        #20 s_rst = 1'b0;
        check("rst_dut0", out0, IDLE0);
        check("rst_dut1", out1, IDLE1);
        chk_en = 1'b1;

        // Simultaneous single transfers: F0 on dut0, A5 on dut1, valid held two cycles
        step();
        valid0 = 1'b1; data0 = 8'hF0;
        valid1 = 1'b1; data1 = 8'hA5;
        @(posedge clk_100);
        cs0_low = 0; cs1_high = 0; lp0_rise = 0; hn1_fall = 0;
        prev_lp0 = 1'b0; prev_hn1 = 1'b1; mos0 = '0; mos1 = '0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk_100);
            if (cs0 == 1'b0) cs0_low++;
            if (cs1 == 1'b1) cs1_high++;
            if (lp0 && !prev_lp0) lp0_rise++;
            if (!hn1 && prev_hn1) hn1_fall++;
            prev_lp0 = lp0;
            prev_hn1 = hn1;
            if (i < 16) mos0 = {mos0[14:0], mosi0};
            if (i < 48 && (i % 6) == 3) mos1 = {mos1[6:0], mosi1};
            if (i == 1) begin valid0 = 1'b0; valid1 = 1'b0; end
        end
        check("f0_cs_low", cs0_low, 17);
        check("f0_lp_rises", lp0_rise, 8);
        check("f0_mosi", mos0, 16'hFF00);
        check("a5_cs_high", cs1_high, 51);
        check("a5_hn_falls", hn1_fall, 8);
        check("a5_mosi", mos1, 8'hA5);

        // Back-to-back with data changing mid-transfer
        step();
        valid0 = 1'b1; data0 = 8'hF0;
        step();
        data0 = 8'h3C;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk_100);
            if (r0) found = 1'b1;
        end
        check("b2b_ready_seen", found, 1'b1);
        @(negedge clk_100);
        check("b2b_next_accept", {r0, mosi0}, 2'b00);
        valid0 = 1'b0;
        repeat (20) step();

        // Synchronous clear during bit 3
        valid0 = 1'b1; data0 = 8'hFF;
        @(posedge clk_100);
        #2 valid0 = 1'b0;
        repeat (6) @(posedge clk_100);
        #2 s_rst = 1'b1;
        @(posedge clk_100);
        #2 s_rst = 1'b0;
        check("srst_idle", out0, IDLE0);
        repeat (5) begin
            @(negedge clk_100);
            check("srst_quiet", out0, IDLE0);
        end

        // Asynchronous reset mid-half-period on the divided instance
        step();
        valid1 = 1'b1; data1 = 8'hFF;
        @(posedge clk_100);
        #2 valid1 = 1'b0;
        repeat (4) @(posedge clk_100);
        #2 a_rst = 1'b1;
        #1 check("arst_dut1", out1, IDLE1);
        check("arst_dut0", out0, IDLE0);
        #19 a_rst = 1'b0;

        // Randomised traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            step();
            valid0 = ($urandom_range(0, 2) == 0);
            valid1 = ($urandom_range(0, 2) == 0);
            data0  = 8'($urandom);
            data1  = 8'($urandom);
            s_rst  = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 99) == 0) begin
                a_rst = 1'b1;
                #1 check("rnd_arst0", out0, IDLE0);
                check("rnd_arst1", out1, IDLE1);
                #1 a_rst = 1'b0;
            end
        end
        step();
        valid0 = 1'b0; valid1 = 1'b0; s_rst = 1'b0;
        repeat (60) step();

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
